// File: rtl/alu_seq_core.sv
// alu_seq_core: multi-cycle ALU with bgn/rdy handshake.
// MUL/DIV/MOD and rotates iterate one step per cycle.
module alu_seq_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bgn,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] acc1,
  output logic [WIDTH-1:0] acc2,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             div0,
  output logic             busy,
  output logic             rdy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_LSR = 5'd3;
  localparam logic [4:0] OP_LSL = 5'd4;
  localparam logic [4:0] OP_RSR = 5'd5;
  localparam logic [4:0] OP_RSL = 5'd6;
  localparam logic [4:0] OP_MUL = 5'd7;
  localparam logic [4:0] OP_DIV = 5'd8;
  localparam logic [4:0] OP_MOD = 5'd9;
  localparam logic [4:0] OP_AND = 5'd10;
  localparam logic [4:0] OP_OR  = 5'd11;
  localparam logic [4:0] OP_XOR = 5'd12;
  localparam logic [4:0] OP_NOT = 5'd13;
  localparam logic [4:0] OP_CMP = 5'd14;
  localparam logic [4:0] OP_TST = 5'd15;
  localparam logic [4:0] OP_INC = 5'd16;
  localparam logic [4:0] OP_DEC = 5'd17;

  logic [0:0]       state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc1_q, acc1_d;
  logic [WIDTH-1:0] acc2_q, acc2_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             div0_q, div0_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH-1:0] add_b, sub_b;
  logic [WIDTH:0]   sum, dif, mul_sum, div_t;
  logic [WIDTH-1:0] div_r;
  logic             div_ge;
  logic [WIDTH-1:0] res1, res2;
  logic             cf, vf, dz, wr, fl;

  // Next-state: accept, iterate, or complete.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    div0_d  = div0_q;
    rdy_d   = 1'b0;

    add_b = (op_q == OP_INC) ? WIDTH'(1) : b_q;
    sub_b = (op_q == OP_DEC) ? WIDTH'(1) : b_q;
    sum   = {1'b0, a_q} + {1'b0, add_b};
    dif   = {1'b0, a_q} - {1'b0, sub_b};
    mul_sum = {1'b0, hi_q}
            + (lo_q[0] ? {1'b0, a_q} : '0);
    div_t  = {hi_q, lo_q[MSB]};
    div_ge = div_t >= {1'b0, b_q};
    div_r  = div_t[MSB:0] - b_q;

    res1 = '0;
    res2 = '0;
    cf   = 1'b0;
    vf   = 1'b0;
    dz   = 1'b0;
    wr   = 1'b1;
    fl   = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bgn) begin
          state_d = S_EXEC;
          op_d    = opcode;
          a_d     = A;
          b_d     = B;
          hi_d    = '0;
          lo_d    = A;
          cnt_d   = '0;
          case (opcode)
            OP_MUL: begin
              lo_d  = B;
              cnt_d = CNT_W'(WIDTH);
            end
            OP_DIV, OP_MOD: begin
              if (B != '0) cnt_d = CNT_W'(WIDTH);
            end
            OP_RSR, OP_RSL: begin
              cnt_d = CNT_W'(B % WIDTH);
            end
            default: ;
          endcase
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          case (op_q)
            OP_MUL: {hi_d, lo_d} =
              {mul_sum, lo_q[MSB:1]};
            OP_DIV, OP_MOD: begin
              hi_d = div_ge ? div_r
                            : div_t[MSB:0];
              lo_d = {lo_q[MSB-1:0], div_ge};
            end
            OP_RSR: lo_d =
              {lo_q[0], lo_q[MSB:1]};
            OP_RSL: lo_d =
              {lo_q[MSB-1:0], lo_q[MSB]};
            default: ;
          endcase
        end else begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
          case (op_q)
            OP_ADD, OP_INC: begin
              res1 = sum[MSB:0];
              cf   = sum[WIDTH];
              vf   = (a_q[MSB] == add_b[MSB]) &&
                     (sum[MSB] != a_q[MSB]);
            end
            OP_SUB, OP_DEC, OP_CMP: begin
              res1 = dif[MSB:0];
              cf   = dif[WIDTH];
              vf   = (a_q[MSB] != sub_b[MSB]) &&
                     (dif[MSB] != a_q[MSB]);
              wr   = (op_q != OP_CMP);
            end
            OP_LSR: res1 = a_q >> b_q;
            OP_LSL: res1 = a_q << b_q;
            OP_RSR, OP_RSL: res1 = lo_q;
            OP_MUL: begin
              res1 = lo_q;
              res2 = hi_q;
              vf   = |hi_q;
            end
            OP_DIV, OP_MOD: begin
              if (b_q == '0) begin
                res1 = '1;
                res2 = a_q;
                dz   = 1'b1;
              end else begin
                res1 = (op_q == OP_DIV) ? lo_q
                                        : hi_q;
                res2 = hi_q;
              end
            end
            OP_AND: res1 = a_q & b_q;
            OP_OR:  res1 = a_q | b_q;
            OP_XOR: res1 = a_q ^ b_q;
            OP_NOT: res1 = ~a_q;
            OP_TST: begin
              res1 = a_q & b_q;
              wr   = 1'b0;
            end
            default: begin
              wr = 1'b0;
              fl = 1'b0;
            end
          endcase
          div0_d = dz;
          if (wr) begin
            acc1_d = res1;
            acc2_d = res2;
          end
          if (fl) begin
            zero_d  = (res1 == '0) && (res2 == '0);
            neg_d   = (op_q == OP_MUL) ? res2[MSB]
                                       : res1[MSB];
            carry_d = cf;
            ovf_d   = vf;
          end
        end
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      div0_q  <= div0_d;
      rdy_q   <= rdy_d;
    end
  end

  assign acc1     = acc1_q;
  assign acc2     = acc2_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign div0     = div0_q;
  assign busy     = (state_q == S_EXEC);
  assign rdy      = rdy_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: scoreboard bench for alu_seq_core.
// A reference model pushes expectations; rdy pops them.
module tb_alu_seq_core;

  typedef struct packed {
    logic [15:0] acc1;
    logic [15:0] acc2;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
    logic        d;
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bgn = 1'b0;
  logic [4:0]  opcode = '0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] acc1, acc2;
  logic        zero, negative, carry;
  logic        overflow, div0, busy, rdy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  exp_t exp_q[$];

  logic [15:0] m1, m2;
  logic        mz, mn, mc, mv, md;

  alu_seq_core #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bgn(bgn),
    .opcode(opcode), .A(A), .B(B),
    .acc1(acc1), .acc2(acc2), .zero(zero),
    .negative(negative), .carry(carry),
    .overflow(overflow), .div0(div0),
    .busy(busy), .rdy(rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    m1 = '0; m2 = '0;
    mz = 0; mn = 0; mc = 0; mv = 0; md = 0;
  endtask

  task automatic model(input logic [4:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b);
    exp_t e;
    logic [15:0] bb, r1, r2;
    logic [31:0] aa, t;
    int su, ss, k;
    bit wr, fl;
    r1 = '0; r2 = '0; wr = 1; fl = 1;
    e = '0;
    e.lat = 8'd1;
    e.c = 0; e.v = 0; e.d = 0;
    aa = {16'h0, a};
    case (op)
      5'd1, 5'd16: begin
        bb = (op == 5'd1) ? b : 16'd1;
        su = int'(a) + int'(bb);
        ss = int'($signed(a)) + int'($signed(bb));
        r1 = su[15:0];
        e.c = su > 65535;
        e.v = (ss > 32767) || (ss < -32768);
      end
      5'd2, 5'd17, 5'd14: begin
        bb = (op == 5'd17) ? 16'd1 : b;
        su = int'(a) - int'(bb);
        ss = int'($signed(a)) - int'($signed(bb));
        r1 = su[15:0];
        e.c = a < bb;
        e.v = (ss > 32767) || (ss < -32768);
        wr = (op != 5'd14);
      end
      5'd3: r1 = (b >= 16) ? 16'h0 : a >> b;
      5'd4: r1 = (b >= 16) ? 16'h0 : a << b;
      5'd5, 5'd6: begin
        k = int'(b) % 16;
        if (op == 5'd5)
          t = (aa >> k) | (aa << (16 - k));
        else
          t = (aa << k) | (aa >> (16 - k));
        r1 = t[15:0];
        e.lat = 8'(k + 1);
      end
      5'd7: begin
        t = aa * {16'h0, b};
        r1 = t[15:0];
        r2 = t[31:16];
        e.v = r2 != 0;
        e.lat = 8'd17;
      end
      5'd8, 5'd9: begin
        if (b == 0) begin
          r1 = 16'hFFFF;
          r2 = a;
          e.d = 1;
        end else begin
          r1 = (op == 5'd8) ? a / b : a % b;
          r2 = a % b;
          e.lat = 8'd17;
        end
      end
      5'd10: r1 = a & b;
      5'd11: r1 = a | b;
      5'd12: r1 = a ^ b;
      5'd13: r1 = ~a;
      5'd15: begin
        r1 = a & b;
        wr = 0;
      end
      default: begin
        wr = 0;
        fl = 0;
      end
    endcase
    if (fl) begin
      mz = (r1 == 0) && (r2 == 0);
      mn = (op == 5'd7) ? r2[15] : r1[15];
      mc = e.c;
      mv = e.v;
    end
    if (wr) begin
      m1 = r1;
      m2 = r2;
    end
    md = e.d;
    e.acc1 = m1; e.acc2 = m2;
    e.z = mz; e.n = mn; e.c = mc; e.v = mv;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [4:0] op,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      output logic b0);
    model(op, a, b);
    @(negedge clk);
    bgn = 1; opcode = op; A = a; B = b;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    b0 = busy;
    bgn = 0;
  endtask

  task automatic collect(input bit noise,
                         output exp_t got,
                         output bit to,
                         output int bcnt);
    bit done;
    int lat;
    done = 0; bcnt = 0; lat = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      lat = cyc - acc_cyc;
      if (rdy) begin
        done = 1;
      end else begin
        if (busy) bcnt++;
        if (noise && lat >= 2 && lat <= 6) begin
          bgn = 1; opcode = 5'd1;
          A = 16'd1; B = 16'd1;
        end else begin
          bgn = 0;
        end
      end
    end
    bgn = 0;
    to = !done;
    got = {acc1, acc2, zero, negative, carry,
           overflow, div0, 8'(lat)};
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({acc1, acc2, zero, negative, carry, overflow,
         div0, busy, rdy} !== '0) begin
      bad++;
      $display("FAIL reset got=%h/%h busy=%b rdy=%b req=0",
               acc1, acc2, busy, rdy);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_add();
    exp_t e, g;
    bit to;
    int bc;
    logic b0;
    send(5'd1, 16'hFFFF, 16'h0001, b0);
    collect(0, g, to, bc);
    e = exp_q.pop_front();
    total++;
    if (to || g !== e) begin
      bad++;
      $display("FAIL add got=%h req=%h", g, e);
    end
    total++;
    if (b0 !== 1'b1) begin
      bad++;
      $display("FAIL add_busy got=%b req=1", b0);
    end
  endtask

  task automatic test_mul();
    exp_t e, g;
    bit to;
    int bc;
    logic b0;
    send(5'd7, 16'h1234, 16'h0100, b0);
    collect(1, g, to, bc);
    e = exp_q.pop_front();
    total++;
    if (to || g !== e) begin
      bad++;
      $display("FAIL mul got=%h req=%h", g, e);
    end
    total++;
    if (bc + int'(b0) !== 17 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mul_busy got=%0d/%b req=17/0",
               bc + int'(b0), busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (rdy !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL mul_ignore got=%b%b req=00",
                 rdy, busy);
      end
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops [3] = '{5'd8, 5'd8, 5'd9};
    logic [15:0] as  [3] = '{16'd100, 16'd5, 16'd100};
    logic [15:0] bs  [3] = '{16'd7, 16'd0, 16'd7};
    exp_t e, g;
    bit to;
    int bc;
    logic b0;
    for (int i = 0; i < 3; i++) begin
      send(ops[i], as[i], bs[i], b0);
      collect(0, g, to, bc);
      e = exp_q.pop_front();
      total++;
      if (to || g !== e) begin
        bad++;
        $display("FAIL div%0d got=%h req=%h", i, g, e);
      end
    end
  endtask

  task automatic test_rot();
    logic [4:0]  ops [4] = '{5'd6, 5'd5, 5'd5, 5'd6};
    logic [15:0] as  [4] = '{16'h8001, 16'h0001,
                             16'h00F1, 16'h0000};
    logic [15:0] bs  [4] = '{16'd17, 16'd0,
                             16'd15, 16'd3};
    exp_t e, g;
    bit to;
    int bc;
    logic b0;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], as[i], bs[i], b0);
      collect(0, g, to, bc);
      e = exp_q.pop_front();
      total++;
      if (to || g !== e) begin
        bad++;
        $display("FAIL rot%0d got=%h req=%h", i, g, e);
      end
    end
  endtask

  task automatic test_sub_cmp();
    logic [4:0]  ops [6] = '{5'd2, 5'd14, 5'd15,
                             5'd31, 5'd3, 5'd4};
    logic [15:0] as  [6] = '{16'h8000, 16'd3, 16'h00F0,
                             16'h1111, 16'hF00F, 16'h00FF};
    logic [15:0] bs  [6] = '{16'h0001, 16'd5, 16'h0F0F,
                             16'h2222, 16'd4, 16'd16};
    exp_t e, g;
    bit to;
    int bc;
    logic b0;
    for (int i = 0; i < 6; i++) begin
      send(ops[i], as[i], bs[i], b0);
      collect(0, g, to, bc);
      e = exp_q.pop_front();
      total++;
      if (to || g !== e) begin
        bad++;
        $display("FAIL subcmp%0d got=%h req=%h",
                 i, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, g;
    bit to;
    int bc;
    logic b0;
    logic [4:0] op;
    logic [15:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 20));
      if (i % 7 == 0) op = 5'($urandom_range(7, 9));
      a = 16'($urandom);
      b = (i % 5 == 0) ? 16'($urandom_range(0, 3))
                       : 16'($urandom);
      send(op, a, b, b0);
      collect(0, g, to, bc);
      e = exp_q.pop_front();
      total++;
      if (to || g !== e) begin
        bad++;
        $display("FAIL b2b%0d op=%0d a=%h b=%h got=%h req=%h",
                 i, op, a, b, g, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e, g;
    bit to;
    int bc;
    logic b0;
    send(5'd7, 16'hABCD, 16'h1234, b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    total++;
    if ({acc1, acc2, zero, negative, carry, overflow,
         div0, busy, rdy} !== '0) begin
      bad++;
      $display("FAIL midrst got=%h/%h busy=%b rdy=%b req=0",
               acc1, acc2, busy, rdy);
    end
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (rdy !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL midrst_idle got=%b%b req=00",
                 rdy, busy);
      end
    end
    send(5'd1, 16'd2, 16'd3, b0);
    collect(0, g, to, bc);
    e = exp_q.pop_front();
    total++;
    if (to || g !== e) begin
      bad++;
      $display("FAIL midrst_add got=%h req=%h", g, e);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_rot();
    test_sub_cmp();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
